// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encoding,
// default word geometry and the default fetch filler word.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  localparam logic [DEF_DATA_WIDTH-1:0] NOP = '0;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_word_assembler.sv
// Packs a byte stream into words; emits a strobe for every completed word and
// for a zero-padded partial word when flushed.
module byte_word_assembler
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  byte_fire_i,
  input  logic [7:0]            byte_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int BPW  = bytes_per_word(DATA_WIDTH);
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d, merged;
  logic                  last;

  // Unfilled lanes of asm_q are always zero, so a flush is already padded.
  always_comb begin
    merged = asm_q;
    if (byte_fire_i) begin
      if (LITTLE_ENDIAN) merged[int'(idx_q)*8 +: 8] = byte_i;
      else               merged[(BPW-1-int'(idx_q))*8 +: 8] = byte_i;
    end
  end

  assign last         = (idx_q == IDXW'(BPW-1));
  assign word_valid_o = (byte_fire_i && last) || (flush_i && (byte_fire_i || idx_q != '0));
  assign word_o       = merged;

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (clear_i || word_valid_o) begin
      idx_d = '0;
      asm_d = '0;
    end else if (byte_fire_i) begin
      idx_d = idx_q + IDXW'(1);
      asm_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory filled from a byte stream by a small loader FSM and read
// combinationally by the fetch stage once loading has finished.
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int                    MEM_DEPTH     = 64,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter bit                    LITTLE_ENDIAN = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD      = DATA_WIDTH'(NOP)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_load_start,
  input  logic                         i_load_end,
  input  logic                         i_byte_valid,
  input  logic [7:0]                   i_byte,
  output logic                         o_byte_ready,
  input  logic [ADDR_WIDTH-1:0]        i_fetch_addr,
  output logic [DATA_WIDTH-1:0]        o_instr,
  output logic                         o_busy,
  output logic                         o_loaded,
  output logic [$clog2(MEM_DEPTH):0]   o_word_count,
  output logic                         o_overflow
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = AW + 1;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  byte_fire, flush;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_valid;
  logic [AW-1:0]         fetch_idx;
  logic                  fetch_hit;

  assign o_byte_ready = (state_q == ST_LOAD) && (count_q < CW'(MEM_DEPTH));
  // A start pulse wins over anything else in its cycle, including data.
  assign byte_fire    = i_byte_valid && o_byte_ready && !i_load_start;
  assign flush        = i_load_end && (state_q == ST_LOAD) && !i_load_start;

  byte_word_assembler #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LITTLE_ENDIAN (LITTLE_ENDIAN)
  ) u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (i_load_start),
    .byte_fire_i  (byte_fire),
    .byte_i       (i_byte),
    .flush_i      (flush),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (i_load_start) begin
      state_d = ST_LOAD;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (word_valid) count_d = count_q + CW'(1);
      if ((state_q == ST_LOAD) && i_byte_valid && !o_byte_ready) ovf_d = 1'b1;
      if ((state_q == ST_LOAD) && i_load_end) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && word_valid) mem[count_q[AW-1:0]] <= word;
  end

  assign fetch_idx = i_fetch_addr[AW+1:2];
  assign fetch_hit = (state_q == ST_READY) && ((i_fetch_addr >> (AW + 2)) == '0)
                     && ({1'b0, fetch_idx} < count_q);

  assign o_instr      = fetch_hit ? mem[fetch_idx] : NOP_WORD;
  assign o_busy       = (state_q == ST_LOAD);
  assign o_loaded     = (state_q == ST_READY);
  assign o_word_count = count_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives three loader configurations (LE/64, BE/64, LE/4) with one shared
// byte stream and checks them against a byte-list model every cycle.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0, load_end = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [31:0] fetch_addr = 32'h0;

  logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, ld0, ld1, ld2, ov0, ov1, ov2;
  logic [31:0] ins0, ins1, ins2;
  logic [6:0]  cnt0, cnt1;
  logic [2:0]  cnt2;

  always #5 clk = ~clk;

  instr_mem_loader u0 (
    .clk(clk), .rst_n(rst_n), .i_load_start(load_start), .i_load_end(load_end),
    .i_byte_valid(byte_valid), .i_byte(byte_in), .o_byte_ready(rdy0),
    .i_fetch_addr(fetch_addr), .o_instr(ins0), .o_busy(busy0), .o_loaded(ld0),
    .o_word_count(cnt0), .o_overflow(ov0));

  instr_mem_loader #(.LITTLE_ENDIAN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .i_load_start(load_start), .i_load_end(load_end),
    .i_byte_valid(byte_valid), .i_byte(byte_in), .o_byte_ready(rdy1),
    .i_fetch_addr(fetch_addr), .o_instr(ins1), .o_busy(busy1), .o_loaded(ld1),
    .o_word_count(cnt1), .o_overflow(ov1));

  instr_mem_loader #(.MEM_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .i_load_start(load_start), .i_load_end(load_end),
    .i_byte_valid(byte_valid), .i_byte(byte_in), .o_byte_ready(rdy2),
    .i_fetch_addr(fetch_addr), .o_instr(ins2), .o_busy(busy2), .o_loaded(ld2),
    .o_word_count(cnt2), .o_overflow(ov2));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: a load is just the list of bytes accepted since the last start.
  int       depth [3] = '{64, 64, 4};
  bit       le    [3] = '{1'b1, 1'b0, 1'b1};
  int       mst   [3];          // 0 idle, 1 load, 2 ready
  bit       movf  [3];
  bit [7:0] bq    [3][$];

  function automatic int m_count(input int i);
    return (mst[i] == 2) ? (bq[i].size() + 3) / 4 : bq[i].size() / 4;
  endfunction

  function automatic bit m_ready(input int i);
    return (mst[i] == 1) && (bq[i].size() / 4 < depth[i]);
  endfunction

  function automatic logic [31:0] m_word(input int i, input int k);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] b = (4*k + j < bq[i].size()) ? 32'(bq[i][4*k + j]) : 32'h0;
      w |= le[i] ? (b << (8*j)) : (b << (8*(3-j)));
    end
    return w;
  endfunction

  function automatic logic [31:0] m_instr(input int i, input logic [31:0] a);
    int aw = $clog2(depth[i]);
    int idx = int'(a >> 2) % depth[i];
    if (mst[i] == 2 && (a >> (aw + 2)) == 0 && idx < m_count(i)) return m_word(i, idx);
    return 32'h0;
  endfunction

  initial for (int i = 0; i < 3; i++) begin mst[i] = 0; movf[i] = 1'b0; end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mst[i] = 0; movf[i] = 1'b0; bq[i].delete();
      end else if (load_start) begin
        mst[i] = 1; movf[i] = 1'b0; bq[i].delete();
      end else if (mst[i] == 1) begin
        if (byte_valid) begin
          if (bq[i].size() / 4 < depth[i]) bq[i].push_back(byte_in);
          else movf[i] = 1'b1;
        end
        if (load_end) mst[i] = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] g_ins [3];
      logic [31:0] g_cnt [3];
      logic        g_rdy [3], g_busy [3], g_ld [3], g_ov [3];
      g_ins  = '{ins0, ins1, ins2};
      g_cnt  = '{32'(cnt0), 32'(cnt1), 32'(cnt2)};
      g_rdy  = '{rdy0, rdy1, rdy2};
      g_busy = '{busy0, busy1, busy2};
      g_ld   = '{ld0, ld1, ld2};
      g_ov   = '{ov0, ov1, ov2};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_busy", i),  32'(g_busy[i]), 32'(mst[i] == 1));
        chk($sformatf("u%0d_loaded", i), 32'(g_ld[i]),  32'(mst[i] == 2));
        chk($sformatf("u%0d_ready", i), 32'(g_rdy[i]),  32'(m_ready(i)));
        chk($sformatf("u%0d_count", i), g_cnt[i],       32'(m_count(i)));
        chk($sformatf("u%0d_ovf", i),   32'(g_ov[i]),   32'(movf[i]));
        chk($sformatf("u%0d_instr", i), g_ins[i],       m_instr(i, fetch_addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1; byte_in = b; tick(); byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1; tick(); load_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_addr = a; #1;
  endtask

  logic [7:0] prog1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    fetch(32'h0);
    chk("rst_instr", ins0, 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_count", 32'(cnt0), 32'h0);

    // two full words
    pulse_start();
    foreach (prog1[k]) send(prog1[k]);
    pulse_end();
    fetch(32'h0);
    chk("lit_le_w0", ins0, 32'h12345678);
    chk("lit_be_w0", ins1, 32'h78563412);
    fetch(32'h4);
    chk("lit_le_w1", ins0, 32'hDEADBEEF);
    chk("lit_d4_w1", ins2, 32'hDEADBEEF);
    chk("lit_count", 32'(cnt0), 32'd2);
    chk("lit_loaded", 32'(ld0), 32'd1);
    fetch(32'h8);
    tick();
    fetch(32'h100);
    chk("lit_upper_nop", ins0, 32'h0);
    fetch(32'h10);
    chk("lit_d4_upper_nop", ins2, 32'h0);
    tick();

    // partial word padded on end
    pulse_start();
    send(8'hAA); send(8'hBB);
    pulse_end();
    fetch(32'h0);
    chk("lit_pad_le", ins0, 32'h0000BBAA);
    chk("lit_pad_be", ins1, 32'hAABB0000);
    chk("lit_pad_count", 32'(cnt0), 32'd1);
    fetch(32'h4);
    chk("lit_beyond_nop", ins0, 32'h0);
    tick();

    // fill the 4-word instance, then offer one more byte
    pulse_start();
    for (int k = 0; k < 16; k++) send(8'(k + 1));
    chk("lit_full_ready", 32'(rdy2), 32'd0);
    chk("lit_full_count", 32'(cnt2), 32'd4);
    send(8'hFF);
    chk("lit_ovf_set", 32'(ov2), 32'd1);
    chk("lit_ovf_count", 32'(cnt2), 32'd4);
    pulse_end();
    fetch(32'hC);
    chk("lit_d4_w3", ins2, 32'h100F0E0D);
    chk("lit_ovf_sticky", 32'(ov2), 32'd1);
    pulse_start();
    chk("lit_ovf_clear", 32'(ov2), 32'd0);

    // gappy stream, last byte in the end cycle
    for (int k = 0; k < 5; k++) begin
      while ($urandom_range(0, 1) == 1) tick();
      send(8'(k + 1));
    end
    byte_valid = 1'b1; byte_in = 8'h06; load_end = 1'b1;
    tick();
    byte_valid = 1'b0; load_end = 1'b0;
    fetch(32'h4);
    chk("lit_end_byte_le", ins0, 32'h00000605);
    chk("lit_end_byte_be", ins1, 32'h05060000);
    fetch(32'h0);
    chk("lit_gap_w0", ins0, 32'h04030201);
    tick();

    // restart mid-load discards the partial progress
    pulse_start();
    for (int k = 0; k < 6; k++) send(8'hC0 + 8'(k));
    pulse_start();
    chk("lit_restart_count", 32'(cnt0), 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    pulse_end();
    chk("lit_restart_word", ins0, 32'h44332211);
    chk("lit_restart_cnt1", 32'(cnt0), 32'd1);

    // reset while loading
    pulse_start();
    send(8'h99); send(8'h88);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lit_rst_busy", 32'(busy0), 32'd0);
    chk("lit_rst_instr", ins0, 32'h0);
    chk("lit_rst_cnt", 32'(cnt0), 32'd0);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
